vx_decode_ibuf: RTL and testbench

VX_DECODE_IBUF -- requirements
Module: VX_decode_ibuf

---
 rtl/vx_decode_ibuf.sv | 155 +++++++++++++++
 tb/tb_vx_decode_ibuf.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_decode_ibuf.sv
// Per-warp decoded-instruction buffer feeding ISSUE_WIDTH issue slices.
// Each slice round-robins over its warps and holds its choice until it fires.
module vx_decode_ibuf #(
    parameter int NUM_WARPS   = 4,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 64,
    localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [WID_W-1:0]                 in_wid,
    output logic                             in_ready,
    input  logic [NUM_WARPS-1:0]             flush,
    output logic [ISSUE_WIDTH-1:0]           out_valid,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] out_data,
    output logic [ISSUE_WIDTH*WID_W-1:0]     out_wid,
    input  logic [ISSUE_WIDTH-1:0]           out_ready,
    output logic [ISSUE_WIDTH-1:0]           ibuf_pop,
    output logic [NUM_WARPS-1:0]             warp_empty
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int PER_SLICE = NUM_WARPS / ISSUE_WIDTH;
    localparam int LIDX_W    = (PER_SLICE > 1) ? $clog2(PER_SLICE) : 1;

    logic [DATA_WIDTH-1:0] mem [NUM_WARPS][DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_WARPS];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_WARPS];
    logic [CNT_W-1:0]      count_q  [NUM_WARPS];

    logic [LIDX_W-1:0]      rr_q       [ISSUE_WIDTH];
    logic [LIDX_W-1:0]      lock_idx_q [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] lock_q;

    logic [LIDX_W-1:0]      sel_idx [ISSUE_WIDTH];
    logic [WID_W-1:0]       sel_wid [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] sel_valid;
    logic [ISSUE_WIDTH-1:0] fire;
    logic [NUM_WARPS-1:0]   nonempty;
    logic [NUM_WARPS-1:0]   push;
    logic [NUM_WARPS-1:0]   pop;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            nonempty[w] = (count_q[w] != '0);
        end
        warp_empty = ~nonempty;
        // Deliberately ignores same-cycle pops: a full queue refuses input.
        in_ready = (count_q[in_wid] < CNT_W'(DEPTH)) && !flush[in_wid];
        for (int w = 0; w < NUM_WARPS; w++) begin
            push[w] = in_valid && in_ready && (in_wid == WID_W'(w));
        end
    end

    // Slice selection: a held lock wins, otherwise first nonempty warp after rr_q.
    always_comb begin
        logic [LIDX_W-1:0] cidx;
        logic [WID_W-1:0]  cwid;
        cidx = '0;
        cwid = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            sel_idx[s]   = lock_idx_q[s];
            sel_wid[s]   = WID_W'(int'(lock_idx_q[s]) * ISSUE_WIDTH + s);
            sel_valid[s] = 1'b0;
            if (lock_q[s]) begin
                sel_valid[s] = nonempty[sel_wid[s]];
            end else begin
                // Descending scan so the nearest candidate after rr_q is kept last.
                for (int i = PER_SLICE; i >= 1; i--) begin
                    cidx = LIDX_W'((int'(rr_q[s]) + i) % PER_SLICE);
                    cwid = WID_W'(int'(cidx) * ISSUE_WIDTH + s);
                    if (nonempty[cwid]) begin
                        sel_idx[s]   = cidx;
                        sel_wid[s]   = cwid;
                        sel_valid[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        out_wid  = '0;
        pop      = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            out_data[s*DATA_WIDTH +: DATA_WIDTH] = mem[sel_wid[s]][rd_ptr_q[sel_wid[s]]];
            out_wid[s*WID_W +: WID_W]            = sel_wid[s];
            if (fire[s]) begin
                pop[sel_wid[s]] = 1'b1;
            end
        end
    end

    assign out_valid = sel_valid;
    assign fire      = sel_valid & out_ready;
    assign ibuf_pop  = fire;

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            mem[in_wid][wr_ptr_q[in_wid]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_q[w] <= '0;
                wr_ptr_q[w] <= '0;
                count_q[w]  <= '0;
            end
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                rr_q[s]       <= '0;
                lock_idx_q[s] <= '0;
            end
            lock_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (flush[w]) begin
                    rd_ptr_q[w] <= '0;
                    wr_ptr_q[w] <= '0;
                    count_q[w]  <= '0;
                end else begin
                    if (push[w]) begin
                        wr_ptr_q[w] <= wr_ptr_q[w] + PTR_W'(1);
                    end
                    if (pop[w]) begin
                        rd_ptr_q[w] <= rd_ptr_q[w] + PTR_W'(1);
                    end
                    if (push[w] && !pop[w]) begin
                        count_q[w] <= count_q[w] + CNT_W'(1);
                    end else if (!push[w] && pop[w]) begin
                        count_q[w] <= count_q[w] - CNT_W'(1);
                    end
                end
            end
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                if (fire[s]) begin
                    rr_q[s]   <= sel_idx[s];
                    lock_q[s] <= 1'b0;
                end else if (sel_valid[s] && !flush[sel_wid[s]]) begin
                    lock_q[s]     <= 1'b1;
                    lock_idx_q[s] <= sel_idx[s];
                end else begin
                    lock_q[s] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_decode_ibuf.sv
// Bench for vx_decode_ibuf: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based model of the buffer.
module tb_vx_decode_ibuf;

    localparam int NW  = 4;
    localparam int IW  = 2;
    localparam int D   = 4;
    localparam int DW  = 64;
    localparam int WW  = 2;
    localparam int PER = NW / IW;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic [WW-1:0]    in_wid;
    logic             in_ready;
    logic [NW-1:0]    flush;
    logic [IW-1:0]    out_valid;
    logic [IW*DW-1:0] out_data;
    logic [IW*WW-1:0] out_wid;
    logic [IW-1:0]    out_ready;
    logic [IW-1:0]    ibuf_pop;
    logic [NW-1:0]    warp_empty;

    int tests = 0;
    int fails = 0;

    // Model: per-warp FIFO contents, last-fired local index and held warp per slice.
    logic [DW-1:0] mq [NW][$];
    int            last  [IW];
    int            lockw [IW];

    vx_decode_ibuf #(
        .NUM_WARPS  (NW),
        .ISSUE_WIDTH(IW),
        .DEPTH      (D),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_wid    (in_wid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_wid   (out_wid),
        .out_ready (out_ready),
        .ibuf_pop  (ibuf_pop),
        .warp_empty(warp_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) mq[w].delete();
        for (int s = 0; s < IW; s++) begin
            last[s]  = 0;
            lockw[s] = -1;
        end
    endtask

    function automatic int pick(input int s);
        if (lockw[s] >= 0 && mq[lockw[s]].size() > 0) return lockw[s];
        for (int k = 1; k <= PER; k++) begin
            int w = ((last[s] + k) % PER) * IW + s;
            if (mq[w].size() > 0) return w;
        end
        return -1;
    endfunction

    // Compare all outputs at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        int            sel [IW];
        logic          exp_ready;
        logic [NW-1:0] exp_empty;
        @(negedge clk);
        exp_ready = (mq[in_wid].size() < D) && !flush[in_wid];
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        for (int w = 0; w < NW; w++) exp_empty[w] = (mq[w].size() == 0);
        check("warp_empty", 64'(warp_empty), 64'(exp_empty));
        for (int s = 0; s < IW; s++) begin
            sel[s] = pick(s);
            check("out_valid", 64'(out_valid[s]), 64'(sel[s] >= 0));
            check("ibuf_pop", 64'(ibuf_pop[s]), 64'(sel[s] >= 0 && out_ready[s]));
            if (sel[s] >= 0) begin
                check("out_wid", 64'(out_wid[s*WW +: WW]), 64'(sel[s]));
                check("out_data", out_data[s*DW +: DW], mq[sel[s]][0]);
            end
        end
        for (int s = 0; s < IW; s++) begin
            if (sel[s] < 0) begin
                lockw[s] = -1;
            end else if (out_ready[s]) begin
                void'(mq[sel[s]].pop_front());
                last[s]  = sel[s] / IW;
                lockw[s] = -1;
            end else begin
                lockw[s] = flush[sel[s]] ? -1 : sel[s];
            end
        end
        if (in_valid && exp_ready) mq[in_wid].push_back(in_data);
        for (int w = 0; w < NW; w++) if (flush[w]) mq[w].delete();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int w, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_wid   = WW'(w);
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic flush_all();
        in_valid = 1'b0;
        flush    = '1;
        cycle();
        flush    = '0;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_wid    = '0;
        flush     = '0;
        out_ready = '0;
        model_reset();
        #12;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_ibuf_pop", 64'(ibuf_pop), 64'(0));
        check("reset_warp_empty", 64'(warp_empty), 64'(4'hF));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fill warp 1; the fifth attempt is refused.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_wid   = 2'd1;
            in_data  = 64'hA0 + 64'(i);
            if (i == 4) begin
                #1;
                check("full_in_ready", 64'(in_ready), 64'(0));
            end
            cycle();
        end
        in_valid = 1'b0;
        #1;
        check("full_out_valid1", 64'(out_valid[1]), 64'(1));
        check("full_out_wid1", 64'(out_wid[3:2]), 64'(1));
        check("full_not_empty", 64'(warp_empty[1]), 64'(0));
        flush_all();

        // Warps 0 and 2 alternate on slice 0.
        push_one(0, 64'hB0);
        push_one(2, 64'hB1);
        push_one(0, 64'hB2);
        push_one(2, 64'hB3);
        out_ready = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_order", 64'(out_wid[1:0]), (k % 2 == 0) ? 64'd0 : 64'd2);
            check("rr_pop", 64'(ibuf_pop[0]), 64'(1));
            cycle();
        end
        check("rr_empty", 64'({warp_empty[2], warp_empty[0]}), 64'(2'b11));

        // Stall on warp 2; a later warp-0 push must not steal the slot.
        out_ready = '0;
        push_one(2, 64'hC0);
        push_one(0, 64'hC1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("lock_wid", 64'(out_wid[1:0]), 64'd2);
            check("lock_data", out_data[DW-1:0], 64'hC0);
            cycle();
        end
        out_ready = 2'b01;
        cycle();
        cycle();
        flush_all();

        // Warp 3 full, then streaming push+pop across pointer wrap.
        out_ready = '0;
        for (int i = 0; i < 4; i++) push_one(3, 64'hD0 + 64'(i));
        out_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_wid   = 2'd3;
            in_data  = 64'hE0 + 64'(i);
            cycle();
            check("stream_nonempty", 64'(warp_empty[3]), 64'(0));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        flush_all();

        // Flush a locked warp while a push to it is offered.
        out_ready = '0;
        push_one(1, 64'hF0);
        push_one(1, 64'hF1);
        cycle();
        flush[1] = 1'b1;
        in_valid = 1'b1;
        in_wid   = 2'd1;
        in_data  = 64'hF2;
        #1;
        check("flush_refuse", 64'(in_ready), 64'(0));
        cycle();
        flush    = '0;
        in_valid = 1'b0;
        #1;
        check("flush_empty", 64'(warp_empty[1]), 64'(1));
        check("flush_valid", 64'(out_valid[1]), 64'(0));
        push_one(3, 64'hF3);
        cycle();
        check("flush_unlock", 64'(out_wid[3:2]), 64'd3);
        flush_all();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom % 4) != 0;
            in_wid    = WW'($urandom % NW);
            in_data   = {$urandom, $urandom};
            out_ready = IW'($urandom);
            for (int w = 0; w < NW; w++) flush[w] = ($urandom % 20) == 0;
            cycle();
        end
        in_valid  = 1'b0;
        flush     = '0;
        out_ready = '0;
        flush_all();

        // Asynchronous reset with entries queued.
        push_one(0, 64'h10);
        push_one(1, 64'h11);
        push_one(2, 64'h12);
        cycle();
        #1;
        reset_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'(0));
        check("async_warp_empty", 64'(warp_empty), 64'(4'hF));
        check("async_in_ready", 64'(in_ready), 64'(1));
        model_reset();
        out_ready = '1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("post_reset_pop", 64'(ibuf_pop), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
